// File: rtl/scr_frame_pkg.sv
// scr_frame_pkg: FSM state type and default sync word for scramble_frame_sequencer.
// The TRAILER state exists only when SCR_FRAME_TRAILER_EN is defined.
package scr_frame_pkg;
    localparam logic [7:0] SCR_SYNC_WORD = 8'hA5;
`ifdef SCR_FRAME_TRAILER_EN
    typedef enum logic [2:0] {IDLE, SEED, SYNC, PAYLOAD, DRAIN, TRAILER} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEED, SYNC, PAYLOAD, DRAIN} state_t;
`endif
endpackage

// File: rtl/scr_frame_checksum.sv
// scr_frame_checksum: running XOR of accepted payload words, cleared at frame start.
// Only built when SCR_FRAME_TRAILER_EN is defined.
`ifdef SCR_FRAME_TRAILER_EN
module scr_frame_checksum #(
    parameter int WORD_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [WORD_LEN-1:0] din,
    output logic [WORD_LEN-1:0] sum
);
    always_ff @(posedge clk) begin
        if (rst || clr) sum <= '0;
        else if (en) sum <= sum ^ din;
    end
endmodule
`endif

// File: rtl/scramble_frame_sequencer.sv
// scramble_frame_sequencer: frames an external scrambler's stream as SYNC_WORD + PAYLOAD_WORDS beats.
// SCR_FRAME_TRAILER_EN adds an XOR trailer beat that carries out_eof.
module scramble_frame_sequencer
    import scr_frame_pkg::*;
#(
    parameter int                  WORD_LEN      = 8,
    parameter int                  PAYLOAD_WORDS = 16,
    parameter logic [WORD_LEN-1:0] SYNC_WORD     = WORD_LEN'(SCR_SYNC_WORD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                scr_rst,
    output logic                scr_ena,
    output logic [WORD_LEN-1:0] scr_din,
    input  logic [WORD_LEN-1:0] scr_dout,
    input  logic                scr_dout_valid,
    output logic [WORD_LEN-1:0] out_data,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eof,
    output logic [15:0]         frame_count
);
    localparam int CW = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_WORDS - 1);

    state_t        state, state_nx, fin;
    logic [CW-1:0] acc_cnt, emit_cnt;
    logic          busy, accept, emit, last_beat, frame_done;

    // Outputs are gated by rst so the reset values hold even on the first reset cycle.
    assign busy      = state == PAYLOAD || state == DRAIN;
    assign in_ready  = !rst && state == PAYLOAD && acc_cnt < CW'(PAYLOAD_WORDS);
    assign accept    = in_valid && in_ready;
    assign emit      = !rst && busy && scr_dout_valid;
    assign last_beat = emit && emit_cnt == LAST;
    assign scr_rst   = rst || state == SEED;
    assign scr_ena   = scr_rst || accept;
    assign scr_din   = in_data;
    assign out_sof   = !rst && state == SYNC;

`ifdef SCR_FRAME_TRAILER_EN
    logic [WORD_LEN-1:0] checksum;

    scr_frame_checksum #(.WORD_LEN(WORD_LEN)) u_checksum (
        .clk (clk),
        .rst (rst),
        .clr (state == SEED),
        .en  (accept),
        .din (in_data),
        .sum (checksum)
    );

    assign fin        = TRAILER;
    assign frame_done = !rst && state == TRAILER;
    assign out_eof    = frame_done;
    assign out_data   = state == SYNC ? SYNC_WORD : state == TRAILER ? checksum : scr_dout;
    assign out_valid  = out_sof || frame_done || emit;
`else
    assign fin        = in_valid ? SEED : IDLE;
    assign frame_done = last_beat;
    assign out_eof    = last_beat;
    assign out_data   = state == SYNC ? SYNC_WORD : scr_dout;
    assign out_valid  = out_sof || emit;
`endif

    // With a zero-latency scrambler the last beat can coincide with the last accept,
    // so completion takes priority over the move to DRAIN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:           state_nx = in_valid ? SEED : IDLE;
            SEED:           state_nx = SYNC;
            SYNC:           state_nx = PAYLOAD;
            PAYLOAD, DRAIN: state_nx = last_beat ? fin : (accept && acc_cnt == LAST) ? DRAIN : state;
`ifdef SCR_FRAME_TRAILER_EN
            TRAILER:        state_nx = in_valid ? SEED : IDLE;
`endif
            default:        state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc_cnt     <= '0;
            emit_cnt    <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_nx;
            acc_cnt     <= state == SEED ? '0 : acc_cnt + CW'(accept);
            emit_cnt    <= state == SEED ? '0 : emit_cnt + CW'(emit);
            frame_count <= frame_count + 16'(frame_done);
        end
    end
endmodule

// File: tb/tb_scramble_frame_sequencer.sv
// tb_scramble_frame_sequencer: randomized frame checks with an additive scrambler model feeding the DUT
// and a descrambler reference reseeded at each sync beat; honours SCR_FRAME_TRAILER_EN.
`timescale 1ns/1ps
module tb_scramble_frame_sequencer;
    localparam int         W       = 8;
    localparam int         N       = 16;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [15:0] KS_SEED = 16'hACE1;
`ifdef SCR_FRAME_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif
    localparam int BEATS = N + 1 + int'(TRL);

    typedef logic [7:0] frame_t [N];
    typedef struct packed {logic sof; logic eof; logic [7:0] data;} beat_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic [W-1:0] in_data = '0, scr_din, scr_dout, out_data;
    logic         in_valid = 1'b0, in_ready, scr_rst, scr_ena, scr_dout_valid;
    logic         out_valid, out_sof, out_eof;
    logic [15:0]  frame_count;

    int    errors = 0, checks = 0, fc_exp = 0, ena_cnt = 0;
    beat_t beats[$];

    always #5 clk = ~clk;

    scramble_frame_sequencer #(.WORD_LEN(W), .PAYLOAD_WORDS(N), .SYNC_WORD(SYNC)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .scr_rst(scr_rst), .scr_ena(scr_ena), .scr_din(scr_din), .scr_dout(scr_dout),
        .scr_dout_valid(scr_dout_valid), .out_data(out_data), .out_valid(out_valid),
        .out_sof(out_sof), .out_eof(out_eof), .frame_count(frame_count)
    );

    function automatic logic [15:0] ks_step(input logic [15:0] s);
        logic [15:0] r = s;
        for (int k = 0; k < 8; k++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        return r;
    endfunction

    // Scrambler stand-in: latency 1 normally, latency 0 when comb is set.
    logic [15:0] lfsr = KS_SEED;
    logic [7:0]  s_q = '0;
    logic        sv_q = 1'b0;
    bit          comb = 1'b0;
    always @(posedge clk) begin
        if (scr_rst) begin
            lfsr <= KS_SEED;
            sv_q <= 1'b0;
        end else if (scr_ena) begin
            s_q  <= scr_din ^ lfsr[7:0];
            sv_q <= 1'b1;
            lfsr <= ks_step(lfsr);
        end else sv_q <= 1'b0;
    end
    assign scr_dout       = comb ? scr_din ^ lfsr[7:0] : s_q;
    assign scr_dout_valid = comb ? scr_ena && !scr_rst : sv_q;

    always @(negedge clk) begin
        if (out_valid) beats.push_back({out_sof, out_eof, out_data});
        if (scr_ena && !scr_rst) ena_cnt = ena_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t pop_beat();
        return beats.size() > 0 ? beats.pop_front() : beat_t'(0);
    endfunction

    task automatic send_frame(input frame_t p, input int mode);
        int i = 0, t = 0;
        bit acc;
        while (i < N && t < 2000) begin
            in_data  = p[i];
            in_valid = mode == 0 ? 1'b1 : mode == 1 ? !in_valid : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            t++;
        end
        check("send", i, N);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beats.size() < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("beats", 32'(beats.size() >= n), 1);
    endtask

    // Reference: sync beat, then payload that descrambles back to p, then optional XOR trailer.
    task automatic check_frame(input frame_t p, input string tag, output frame_t scr);
        logic [15:0] ks = KS_SEED;
        logic [7:0]  x = '0;
        beat_t       b;
        b = pop_beat();
        check({tag, " sync"}, {b.sof, b.eof, b.data}, {2'b10, SYNC});
        for (int i = 0; i < N; i++) begin
            b = pop_beat();
            scr[i] = b.data;
            x ^= p[i];
            check({tag, " payload"}, {b.sof, b.eof, b.data ^ ks[7:0]}, {1'b0, (i == N - 1) && !TRL, p[i]});
            ks = ks_step(ks);
        end
`ifdef SCR_FRAME_TRAILER_EN
        b = pop_beat();
        check({tag, " trailer"}, {b.sof, b.eof, b.data}, {2'b01, x});
`endif
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        beats.delete();
        fc_exp = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        frame_t seq, seq1, rnd, s1, s2, s3;
        int e0, acc_n, t;
        bit acc, same;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 8'(i);
            seq1[i] = 8'(i + 1);
        end
        @(negedge clk);
        check("rst out", {out_valid, in_ready, out_sof, out_eof, scr_rst, scr_ena}, 6'b000011);
        check("rst frame_count", frame_count, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle", {out_valid, in_ready, scr_rst, scr_ena}, 4'b0000);

        send_frame(seq, 0);
        in_valid = 1'b0;
        wait_beats(BEATS);
        check_frame(seq, "cont", s1);
        fc_exp++;
        check("fc cont", frame_count, fc_exp);

        e0 = ena_cnt;
        send_frame(seq, 1);
        in_valid = 1'b0;
        wait_beats(BEATS);
        check("ena pulses", ena_cnt - e0, N);
        check_frame(seq, "toggle", s1);
        fc_exp++;
        check("fc toggle", frame_count, fc_exp);

        reset_dut();
        for (int i = 0; i < N; i++) rnd[i] = 8'($urandom);
        repeat (3) send_frame(rnd, 0);
        in_valid = 1'b0;
        wait_beats(3 * BEATS);
        check_frame(rnd, "b2b1", s1);
        check_frame(rnd, "b2b2", s2);
        check_frame(rnd, "b2b3", s3);
        same = 1'b1;
        for (int i = 0; i < N; i++) same &= s2[i] == s1[i] && s3[i] == s1[i];
        check("reseed", 32'(same), 1);
        fc_exp += 3;
        check("fc b2b", frame_count, fc_exp);

        acc_n = 0;
        t = 0;
        in_valid = 1'b1;
        while (acc_n < 5 && t < 100) begin
            in_data = seq[acc_n];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) acc_n++;
            t++;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid rst", {out_valid, in_ready, out_sof, out_eof, scr_rst, scr_ena}, 6'b000011);
        @(posedge clk); #1 rst = 1'b0;
        beats.delete();
        fc_exp = 0;
        @(negedge clk);
        check("after rst", {out_valid, in_ready, scr_rst, scr_ena}, 4'b0000);
        check("fc after rst", frame_count, fc_exp);
        send_frame(seq, 0);
        in_valid = 1'b0;
        wait_beats(BEATS);
        check_frame(seq, "post rst", s1);
        fc_exp++;
        check("fc post rst", frame_count, fc_exp);

        comb = 1'b1;
        for (int i = 0; i < N; i++) rnd[i] = 8'($urandom);
        repeat (2) send_frame(rnd, 0);
        in_valid = 1'b0;
        wait_beats(2 * BEATS);
        check_frame(rnd, "lat0 f1", s1);
        check_frame(rnd, "lat0 f2", s2);
        fc_exp += 2;
        check("fc lat0", frame_count, fc_exp);
        reset_dut();
        comb = 1'b0;

        repeat (4) begin
            for (int i = 0; i < N; i++) rnd[i] = 8'($urandom);
            send_frame(rnd, 2);
            in_valid = 1'b0;
            wait_beats(BEATS);
            check_frame(rnd, "rand", s1);
            fc_exp++;
            check("fc rand", frame_count, fc_exp);
        end

        send_frame(seq1, 0);
        in_valid = 1'b0;
        wait_beats(BEATS);
        check_frame(seq1, "seq1", s1);
        fc_exp++;
        check("fc seq1", frame_count, fc_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
